// File: rtl/serial_io_port_pkg.sv
// -----------------------------------------------------------------------------
// serial_io_port_pkg
// Shared constants for the byte-serial I/O port: port offsets relative to
// BASE_ADDR, status-word bit positions, and the TX/RX FSM state encodings.
// Also provides the status-word packing helper used by the read mux.
// -----------------------------------------------------------------------------
package serial_io_port_pkg;

    // Port offsets from BASE_ADDR
    localparam logic [15:0] DATA_OFS = 16'd0;
    localparam logic [15:0] STAT_OFS = 16'd1;

    // Status word bit positions
    localparam int RX_AVAIL  = 0;
    localparam int TX_FULL   = 1;
    localparam int OVERRUN   = 2;
    localparam int FRAME_ERR = 3;

    // Serialiser states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Deserialiser states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Packs the four status flags into the 16-bit status word
    function automatic logic [15:0] status_word(input logic frame_err,
                                                input logic overrun,
                                                input logic tx_full,
                                                input logic rx_avail);
        logic [15:0] w;
        w            = 16'h0000;
        w[FRAME_ERR] = frame_err;
        w[OVERRUN]   = overrun;
        w[TX_FULL]   = tx_full;
        w[RX_AVAIL]  = rx_avail;
        return w;
    endfunction

endpackage

// File: rtl/serial_io_port_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
// Small synchronous FIFO (DEPTH must be a power of two, >= 2).
// A push while full succeeds only if a pop happens in the same cycle, so a
// full FIFO can be written and drained simultaneously with count unchanged.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (empties the FIFO)
//   i_push   write request; ignored when full and not popping
//   i_din    write data
//   i_pop    read request; ignored when empty
//   o_full   count == DEPTH
//   o_empty  count == 0
//   o_head   oldest entry (undefined content when empty)
// -----------------------------------------------------------------------------
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage, pointers and occupancy count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/serial_io_port.sv
// -----------------------------------------------------------------------------
// serial_io_port
// Byte-serial 8N1 I/O device on the CPU I/O bus.
//   BASE_ADDR   : data port (write = TX push, read = RX pop)
//   BASE_ADDR+1 : status port (read = {frame_err, overrun, tx_full, rx_avail},
//                 write = clear sticky errors)
// Ports:
//   clk   system clock
//   RST   synchronous active-high reset
//   addr  CPU I/O address
//   bus   CPU data bus, driven only while DO hits one of our ports
//   DI    CPU write strobe
//   DO    CPU read strobe (one clk per read)
//   tx    serial out, idle high
//   rx    serial in, asynchronous
// -----------------------------------------------------------------------------
module serial_io_port
    import serial_io_port_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'h0001,
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [15:0] addr,
    inout  wire  [15:0] bus,
    input  logic        DI,
    input  logic        DO,
    output logic        tx,
    input  logic        rx
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_MAX = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [15:0]   DATA_ADDR = BASE_ADDR + DATA_OFS;
    localparam logic [15:0]   STAT_ADDR = BASE_ADDR + STAT_OFS;

    // ---------------- bus decode ----------------
    logic        w_data_sel;
    logic        w_stat_sel;
    logic        w_bus_oe;
    logic [15:0] w_rd_data;
    logic        w_stat_wr;

    assign w_data_sel = (addr == DATA_ADDR);
    assign w_stat_sel = (addr == STAT_ADDR);
    assign w_bus_oe   = DO && (w_data_sel || w_stat_sel);
    assign w_stat_wr  = DI && w_stat_sel;

    // ---------------- FIFOs ----------------
    logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic [7:0] w_tx_head;
    logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0] w_rx_head;

    assign w_tx_push = DI && w_data_sel;
    assign w_rx_pop  = DO && w_data_sel;

    byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (clk),
        .i_rst   (RST),
        .i_push  (w_tx_push),
        .i_din   (bus[7:0]),
        .i_pop   (w_tx_pop),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_head  (w_tx_head)
    );

    logic [7:0] r_rx_shift;

    byte_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (clk),
        .i_rst   (RST),
        .i_push  (w_rx_push),
        .i_din   (r_rx_shift),
        .i_pop   (w_rx_pop),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_head  (w_rx_head)
    );

    // ---------------- read mux ----------------
    logic r_overrun;
    logic r_frame_err;

    // Read data for whichever port is addressed; empty RX reads as zero
    always_comb begin
        w_rd_data = 16'h0000;
        if (w_stat_sel) begin
            w_rd_data = status_word(r_frame_err, r_overrun, w_tx_full, !w_rx_empty);
        end else if (w_data_sel && !w_rx_empty) begin
            w_rd_data = {8'h00, w_rx_head};
        end else begin
            w_rd_data = 16'h0000;
        end
    end

    assign bus = w_bus_oe ? w_rd_data : 16'hzzzz;

    // ---------------- serialiser ----------------
    tx_state_t   r_tx_state;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;
    logic        r_tx;
    logic        w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == BAUD_MAX);
    // Pop from idle, or straight out of a finished stop bit for back-to-back frames
    assign w_tx_pop = !w_tx_empty &&
                      ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_bit_end));
    assign tx = r_tx;

    // TX FSM: start bit, 8 data bits LSB-first, stop bit; tx is registered
    always_ff @(posedge clk) begin
        if (RST) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    r_tx_cnt <= '0;
                    r_tx_bit <= 3'd0;
                    if (!w_tx_empty) begin
                        r_tx_shift <= w_tx_head;
                        r_tx_state <= TX_START;
                        r_tx       <= 1'b0;
                    end else begin
                        r_tx       <= 1'b1;
                    end
                end
                TX_START: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= 3'd0;
                        r_tx_state <= TX_DATA;
                        r_tx       <= r_tx_shift[0];
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_DATA: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_tx_state <= TX_STOP;
                            r_tx       <= 1'b1;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx       <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                TX_STOP: begin
                    if (w_tx_bit_end) begin
                        r_tx_cnt <= '0;
                        if (!w_tx_empty) begin
                            r_tx_shift <= w_tx_head;
                            r_tx_state <= TX_START;
                            r_tx       <= 1'b0;
                        end else begin
                            r_tx_state <= TX_IDLE;
                            r_tx       <= 1'b1;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_tx_state <= TX_IDLE;
                    r_tx_cnt   <= '0;
                    r_tx       <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- deserialiser ----------------
    logic r_rx_meta;
    logic r_rx_sync;
    logic r_rx_prev;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    rx_state_t     r_rx_state;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic          w_rx_stop_smp;
    logic          w_ovr_set;
    logic          w_ferr_set;

    assign w_rx_stop_smp = (r_rx_state == RX_STOP) && (r_rx_cnt == BAUD_MAX);
    assign w_rx_push     = w_rx_stop_smp && r_rx_sync;
    assign w_ferr_set    = w_rx_stop_smp && !r_rx_sync;
    // A simultaneous CPU pop makes room, so a full FIFO only overruns without one
    assign w_ovr_set     = w_rx_push && w_rx_full && !w_rx_pop;

    // RX FSM: start bit checked at mid-bit, then data/stop sampled every bit period
    always_ff @(posedge clk) begin
        if (RST) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= 3'd0;
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BAUD_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'd7) begin
                            r_rx_state <= RX_STOP;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BAUD_MAX) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_rx_state <= RX_IDLE;
                    r_rx_cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle is kept
    always_ff @(posedge clk) begin
        if (RST) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_stat_wr) begin
                r_overrun <= 1'b0;
            end
            if (w_ferr_set) begin
                r_frame_err <= 1'b1;
            end else if (w_stat_wr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_io_port.sv
// -----------------------------------------------------------------------------
// tb_serial_io_port
// Directed bench for serial_io_port (CLK_DIV=4, FIFO_DEPTH=4, BASE_ADDR=1).
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_serial_io_port;

    localparam logic [15:0] DATA_A  = 16'h0001;
    localparam logic [15:0] STAT_A  = 16'h0002;
    localparam int          BIT_CYC = 4;

    logic        clk = 1'b0;
    logic        RST;
    logic [15:0] addr;
    wire  [15:0] bus;
    logic        DI;
    logic        DO;
    wire         tx;
    logic        rx;
    logic        tb_drv_en;
    logic [15:0] tb_drv;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    assign bus = tb_drv_en ? tb_drv : 16'hzzzz;

    serial_io_port #(
        .BASE_ADDR  (16'h0001),
        .CLK_DIV    (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk  (clk),
        .RST  (RST),
        .addr (addr),
        .bus  (bus),
        .DI   (DI),
        .DO   (DO),
        .tx   (tx),
        .rx   (rx)
    );

    // Line-level 8N1 decoder on tx: mid-bit sampling from the first low cycle
    logic [7:0] dec_byte;
    logic       dec_busy = 1'b0;
    int         dec_cnt  = 0;
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (!dec_busy) begin
            if (tx == 1'b0) begin
                dec_busy <= 1'b1;
                dec_cnt  <= 1;
            end
        end else begin
            if (dec_cnt >= 6 && dec_cnt <= 34 && ((dec_cnt - 6) % 4) == 0) begin
                dec_byte[3'((dec_cnt - 6) / 4)] <= tx;
            end
            if (dec_cnt == 38 && tx == 1'b1) begin
                tx_q.push_back(dec_byte);
            end
            if (dec_cnt == 39) begin
                dec_busy <= 1'b0;
            end
            dec_cnt <= dec_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        addr      = a;
        tb_drv    = d;
        tb_drv_en = 1'b1;
        DI        = 1'b1;
        @(negedge clk);
        DI        = 1'b0;
        tb_drv_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a, output logic [15:0] d);
        addr = a;
        DO   = 1'b1;
        #1;
        d    = bus;
        @(negedge clk);
        DO   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        cpu_read(a, d);
        check_eq(tag, {48'h0, d}, {48'h0, exp});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx = 1'b1;
    endtask

    // Bus not claimed by the DUT: a value driven by the bench reads back intact
    task automatic bus_free_check(input string tag);
        addr      = DATA_A;
        tb_drv    = 16'hA5C3;
        tb_drv_en = 1'b1;
        #1;
        check_eq(tag, {48'h0, bus}, 64'h0000_0000_0000_A5C3);
        @(negedge clk);
        tb_drv_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] obs;
        logic [63:0] exp;
        logic [7:0]  tx_byte;
        int          lows;

        RST = 1'b1; DI = 1'b0; DO = 1'b0; rx = 1'b1;
        addr = 16'h0000; tb_drv_en = 1'b0; tb_drv = 16'h0000;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_tx", {63'h0, tx}, 64'h1);
        read_check("rst_status", STAT_A, 16'h0000);
        read_check("rst_data", DATA_A, 16'h0000);
        bus_free_check("rst_bus_free");

        // Single byte out: exact per-cycle waveform of one 8N1 frame
        tx_byte = 8'hA5;
        cpu_write(DATA_A, 16'h00A5);
        check_eq("tx1_pre_idle", {63'h0, tx}, 64'h1);
        obs = 64'h0;
        exp = 64'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            obs[k] = tx;
            if (k < 4)       exp[k] = 1'b0;
            else if (k < 36) exp[k] = tx_byte[(k - 4) / 4];
            else             exp[k] = 1'b1;
        end
        check_eq("tx1_frame", obs, exp);
        @(negedge clk);
        check_eq("tx1_post_idle", {63'h0, tx}, 64'h1);
        repeat (4) @(negedge clk);

        // TX backpressure: six back-to-back writes, 06 dropped
        tx_q.delete();
        for (int i = 1; i <= 6; i++) begin
            cpu_write(DATA_A, 16'(i));
        end
        read_check("bp_status_full", STAT_A, 16'h0002);
        repeat (220) @(negedge clk);
        check_eq("bp_frames", 64'(tx_q.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < tx_q.size()) begin
                check_eq($sformatf("bp_byte%0d", i), {56'h0, tx_q[i]}, 64'(i + 1));
            end else begin
                check_eq($sformatf("bp_byte%0d_missing", i), 64'd0, 64'(i + 1));
            end
        end
        read_check("bp_status_drained", STAT_A, 16'h0000);

        // Receive one frame
        send_rx(8'h3C, 1'b1);
        repeat (6) @(negedge clk);
        read_check("rx_status_avail", STAT_A, 16'h0001);
        read_check("rx_data", DATA_A, 16'h003C);
        read_check("rx_status_empty", STAT_A, 16'h0000);

        // Overrun: five frames without reading
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(8'h11 * i), 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        read_check("ovr_status", STAT_A, 16'h0005);
        read_check("ovr_rd0", DATA_A, 16'h0011);
        read_check("ovr_rd1", DATA_A, 16'h0022);
        read_check("ovr_rd2", DATA_A, 16'h0033);
        read_check("ovr_rd3", DATA_A, 16'h0044);
        read_check("ovr_rd_empty", DATA_A, 16'h0000);

        // Frame error: stop bit 0
        send_rx(8'hF0, 1'b0);
        repeat (6) @(negedge clk);
        read_check("ferr_status", STAT_A, 16'h000C);
        read_check("ferr_no_data", DATA_A, 16'h0000);
        cpu_write(STAT_A, 16'h00FF);
        read_check("err_cleared", STAT_A, 16'h0000);

        // Glitch reject, then a good frame proves the RX FSM is idle again
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        read_check("glitch_status", STAT_A, 16'h0000);
        send_rx(8'h5A, 1'b1);
        repeat (6) @(negedge clk);
        read_check("glitch_after_rx", DATA_A, 16'h005A);

        // Reset during data bit 3 with two bytes still queued
        cpu_write(DATA_A, 16'h0081);
        cpu_write(DATA_A, 16'h007E);
        cpu_write(DATA_A, 16'h00C3);
        repeat (16) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        check_eq("mrst_tx", {63'h0, tx}, 64'h1);
        read_check("mrst_status", STAT_A, 16'h0000);
        bus_free_check("mrst_bus_free");
        lows = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check_eq("mrst_no_frames", 64'(lows), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
